// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: 16-bit add/subtract sequenced as four 4-bit nibbles,
// least significant first, through one nibble datapath with a registered carry.

// Nibble add/sub datapath with explicit carry-in; also exposes the carry into
// bit 3 so the caller can derive signed overflow on the top nibble.
module serial_addsub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] bx;
  logic [4:0] sum5;
  logic [3:0] low4;

  // Combinational nibble sum with B conditionally inverted for subtract
  always_comb begin
    bx   = b ^ {4{sub}};
    sum5 = {1'b0, a} + {1'b0, bx} + {4'b0000, cin};
    low4 = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    s    = sum5[3:0];
    cout = sum5[4];
    c3   = low4[3];
  end

endmodule

module serial_addsub_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        sub_q;
  logic        c;

  logic [3:0]  nib_s;
  logic        nib_cout;
  logic        nib_c3;

  serial_addsub_nibble u_nibble (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .sub  (sub_q),
    .cin  (c),
    .s    (nib_s),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  // Sequencer: accept a request, run four nibbles, then pulse done for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      c         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            c     <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= nib_s;
          c   <= nib_cout;
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            carry_out <= nib_cout;
            overflow  <= nib_cout ^ nib_c3;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed and randomized checks of serial_addsub_ctrl
// against a whole-word arithmetic reference model.
module tb_serial_addsub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;

  int unsigned n_cmp;
  int unsigned n_err;

  serial_addsub_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, overflow, result} from 16-bit two's-complement arithmetic
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [16:0] full;
    logic [15:0] r;
    logic        v;
    if (s) full = {1'b0, x} + {1'b0, ~y} + 17'd1;
    else   full = {1'b0, x} + {1'b0, y};
    r = full[15:0];
    if (s) v = (x[15] != y[15]) && (r[15] != x[15]);
    else   v = (x[15] == y[15]) && (r[15] != x[15]);
    return {full[16], v, r};
  endfunction

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s, input string tag);
    logic [17:0] exp;
    int unsigned lat;
    exp = model(x, y, s);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    check({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 8) begin
      check({tag, ".busyrun"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 32'd4);
    check({tag, ".result"}, {16'd0, result}, {16'd0, exp[15:0]});
    check({tag, ".carry"}, {31'd0, carry_out}, {31'd0, exp[17]});
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp[16]});
    check({tag, ".busydone"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".doneoff"}, {31'd0, done}, 32'd0);
    check({tag, ".hold"}, {16'd0, result}, {16'd0, exp[15:0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    logic        exp_done;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.result", {16'd0, result}, 32'd0);
    check("rst.flags", {30'd0, carry_out, overflow}, 32'd0);
    rst = 1'b0;

    do_op(16'h1234, 16'h0FFF, 1'b0, "add_basic");
    do_op(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    do_op(16'h0000, 16'h0001, 1'b1, "sub_borrow");
    do_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      do_op(ra, rb, rs, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Start held high: done every 5 cycles, A changed during RUN
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      exp_done = ((k % 5) == 4);
      check("b2b.done", {31'd0, done}, {31'd0, exp_done});
      check("b2b.busy", {31'd0, busy}, {31'd0, ~exp_done});
      if (exp_done) begin
        check("b2b.result", {16'd0, result}, 32'd0);
        check("b2b.carry", {31'd0, carry_out}, 32'd1);
      end
      if ((k % 5) == 1) a = 16'h1234;
      if ((k % 5) == 3) a = 16'hFFFF;
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("b2b.idle", {30'd0, busy, done}, 32'd0);

    // Reset at the second RUN edge discards the operation
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst.busy", {31'd0, busy}, 32'd0);
    check("mrst.done", {31'd0, done}, 32'd0);
    check("mrst.result", {16'd0, result}, 32'd0);
    check("mrst.flags", {30'd0, carry_out, overflow}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("mrst.nodone", {30'd0, busy, done}, 32'd0);
    end
    do_op(16'h0003, 16'h0004, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
